grf_wport_arbiter: RTL and testbench

- Shares the register file's single write port among three writers:
  - the main pipeline writeback (P);
  - two long-latency secondary writers (S0, S1), e.g. multiply/divide unit and coprocessor/slow load.
- Grants at most one write per cycle and registers it toward the register file.
- Exports a pending-write mask for the hazard unit.
- Bounds secondary wait time by stalling the pipeline.

---
 rtl/grf_wport_arbiter.sv | 126 ++++++++++++
 tb/tb_grf_wport_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (P) vs two long-latency writers (S0, S1).
// Define GRF_ARB_TRACE_EN to print every accepted request in simulation.
module grf_wport_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    output logic        stall,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [4:0]  s0_a3,
    input  logic [31:0] s0_wd,
    input  logic [31:0] s0_pc,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_a3,
    input  logic [31:0] s1_wd,
    input  logic [31:0] s1_pc,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [31:0] pend_mask
);

    typedef enum logic [1:0] {GNT_NONE, GNT_P, GNT_S0, GNT_S1} gnt_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    gnt_e             gnt;
    logic             rr;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             p_real, s0_real, s1_real;
    logic             s0_starve, s1_starve;

    // Writes to $0 never need the port, so only non-zero destinations compete.
    assign p_real    = p_valid  && (p_a3  != 5'd0);
    assign s0_real   = s0_valid && (s0_a3 != 5'd0);
    assign s1_real   = s1_valid && (s1_a3 != 5'd0);
    assign s0_starve = s0_real && (cnt0 == LIMIT);
    assign s1_starve = s1_real && (cnt1 == LIMIT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt = GNT_NONE;
        if (!reset)
            gnt = GNT_NONE;
        else if (s0_starve && s1_starve)
            gnt = rr ? GNT_S1 : GNT_S0;
        else if (s0_starve)
            gnt = GNT_S0;
        else if (s1_starve)
            gnt = GNT_S1;
        else if (p_real)
            gnt = GNT_P;
        else if (s0_real && s1_real)
            gnt = rr ? GNT_S1 : GNT_S0;
        else if (s0_real)
            gnt = GNT_S0;
        else if (s1_real)
            gnt = GNT_S1;
    end

    assign stall    = reset && (s0_starve || s1_starve);
    assign s0_ready = reset && s0_valid && ((s0_a3 == 5'd0) || (gnt == GNT_S0));
    assign s1_ready = reset && s1_valid && ((s1_a3 == 5'd0) || (gnt == GNT_S1));

    always_comb begin
        pend_mask = '0;
        if (s0_valid && gnt != GNT_S0) pend_mask[s0_a3] = 1'b1;
        if (s1_valid && gnt != GNT_S1) pend_mask[s1_a3] = 1'b1;
        if (grf_we)                    pend_mask[grf_a3] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
            rr     <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            grf_we <= (gnt != GNT_NONE);
            case (gnt)
                GNT_P:  begin grf_a3 <= p_a3;  grf_wd <= p_wd;  grf_pc <= p_pc;  end
                GNT_S0: begin grf_a3 <= s0_a3; grf_wd <= s0_wd; grf_pc <= s0_pc; rr <= 1'b1; end
                GNT_S1: begin grf_a3 <= s1_a3; grf_wd <= s1_wd; grf_pc <= s1_pc; rr <= 1'b0; end
                default: ;
            endcase

            // Wait counters only run while a real request is held off the port.
            if (!s0_real || s0_ready)
                cnt0 <= '0;
            else if (cnt0 != LIMIT)
                cnt0 <= cnt0 + CNT_W'(1);

            if (!s1_real || s1_ready)
                cnt1 <= '0;
            else if (cnt1 != LIMIT)
                cnt1 <= cnt1 + CNT_W'(1);
        end
    end

`ifdef GRF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (reset) begin
            if (p_valid && !stall)
                $display("grf_arb: P  pc=%h a3=%0d wd=%h stall=%b", p_pc, p_a3, p_wd, stall);
            if (s0_ready)
                $display("grf_arb: S0 pc=%h a3=%0d wd=%h stall=%b", s0_pc, s0_a3, s0_wd, stall);
            if (s1_ready)
                $display("grf_arb: S1 pc=%h a3=%0d wd=%h stall=%b", s1_pc, s1_a3, s1_wd, stall);
        end
    end
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Bench for grf_wport_arbiter: directed scenarios followed by protocol-legal random traffic,
// all compared against a rule-level reference model of the arbiter.
module tb_grf_wport_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid;
    logic [4:0]  p_a3;
    logic [31:0] p_wd, p_pc;
    logic        stall;
    logic        s_valid [2];
    logic [4:0]  s_a3    [2];
    logic [31:0] s_wd    [2];
    logic [31:0] s_pc    [2];
    logic        s0_ready, s1_ready;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc, pend_mask;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          m_wait [2];
    int          m_pref;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd, m_pc;
    // Per-cycle prediction (winner: -1 none, 0/1 secondary, 2 pipeline)
    int          m_win;
    logic        m_stall;
    logic        m_ready [2];
    logic [31:0] m_pend;

    grf_wport_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc), .stall(stall),
        .s0_valid(s_valid[0]), .s0_ready(s0_ready), .s0_a3(s_a3[0]), .s0_wd(s_wd[0]), .s0_pc(s_pc[0]),
        .s1_valid(s_valid[1]), .s1_ready(s1_ready), .s1_a3(s_a3[1]), .s1_wd(s_wd[1]), .s1_pc(s_pc[1]),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_wait[0] = 0; m_wait[1] = 0; m_pref = 0;
        m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
        m_stall = 1'b0; m_ready[0] = 1'b0; m_ready[1] = 1'b0; m_win = -1;
    endfunction

    function automatic void predict();
        bit real_s [2];
        bit starving [2];
        bit real_p;
        real_p = p_valid && p_a3 != 0;
        for (int i = 0; i < 2; i++) begin
            real_s[i]   = s_valid[i] && s_a3[i] != 0;
            starving[i] = real_s[i] && m_wait[i] >= LIMIT;
        end
        m_win = -1;
        m_stall = 1'b0;
        if (starving[0] || starving[1]) begin
            m_stall = 1'b1;
            m_win = (starving[0] && starving[1]) ? m_pref : (starving[0] ? 0 : 1);
        end else if (real_p)                m_win = 2;
        else if (real_s[0] && real_s[1])    m_win = m_pref;
        else if (real_s[0])                 m_win = 0;
        else if (real_s[1])                 m_win = 1;
        m_pend = '0;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = s_valid[i] && (s_a3[i] == 0 || m_win == i);
            if (real_s[i] && m_win != i) m_pend[s_a3[i]] = 1'b1;
        end
        if (m_we) m_pend[m_a3] = 1'b1;
        m_pend[0] = 1'b0;
    endfunction

    function automatic void commit();
        m_we = (m_win >= 0);
        if (m_win == 2) begin
            m_a3 = p_a3; m_wd = p_wd; m_pc = p_pc;
        end else if (m_win >= 0) begin
            m_a3 = s_a3[m_win]; m_wd = s_wd[m_win]; m_pc = s_pc[m_win];
        end
        if (m_win == 0) m_pref = 1;
        else if (m_win == 1) m_pref = 0;
        for (int i = 0; i < 2; i++) begin
            if (!(s_valid[i] && s_a3[i] != 0) || m_ready[i]) m_wait[i] = 0;
            else if (m_wait[i] < LIMIT) m_wait[i]++;
        end
    endfunction

    // Inputs are applied shortly after a rising edge; outputs are compared at the falling edge.
    task automatic settle(input string tag);
        predict();
        @(negedge clk);
        check({tag, ".stall"},     32'(stall),    32'(m_stall));
        check({tag, ".s0_ready"},  32'(s0_ready), 32'(m_ready[0]));
        check({tag, ".s1_ready"},  32'(s1_ready), 32'(m_ready[1]));
        check({tag, ".pend_mask"}, pend_mask,     m_pend);
        check({tag, ".grf_we"},    32'(grf_we),   32'(m_we));
        check({tag, ".grf_a3"},    32'(grf_a3),   32'(m_a3));
        check({tag, ".grf_wd"},    grf_wd,        m_wd);
        check({tag, ".grf_pc"},    grf_pc,        m_pc);
    endtask

    task automatic advance();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0;
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
    endfunction

    initial begin
        reset = 1'b0;
        p_valid = 1'b0; p_a3 = '0; p_wd = '0; p_pc = '0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_a3[i] = '0; s_wd[i] = '0; s_pc[i] = '0;
        end
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        check("rst.grf_we", 32'(grf_we), 32'd0);
        check("rst.grf_a3", 32'(grf_a3), 32'd0);
        check("rst.stall",  32'(stall),  32'd0);
        reset = 1'b1;

        // Pipeline-only write
        p_valid = 1'b1; p_a3 = 5'd5; p_wd = 32'h1234; p_pc = 32'h3000;
        settle("p_only");
        advance();
        idle();
        check("p_only.we", 32'(grf_we), 32'd1);
        check("p_only.a3", 32'(grf_a3), 32'd5);
        check("p_only.wd", grf_wd, 32'h1234);
        check("p_only.pc", grf_pc, 32'h3000);
        settle("p_only_next");
        advance();

        // Two secondaries, round robin from rr=0
        s_valid[0] = 1'b1; s_a3[0] = 5'd8; s_wd[0] = 32'h8888; s_pc[0] = 32'h800;
        s_valid[1] = 1'b1; s_a3[1] = 5'd9; s_wd[1] = 32'h9999; s_pc[1] = 32'h900;
        settle("rr_a");
        check("rr_a.s0_ready", 32'(s0_ready), 32'd1);
        advance();
        s_valid[0] = 1'b0;
        settle("rr_b");
        check("rr_b.s1_ready", 32'(s1_ready), 32'd1);
        check("rr_b.grf_a3",   32'(grf_a3),   32'd8);
        advance();
        idle();
        check("rr_c.grf_a3", 32'(grf_a3), 32'd9);
        settle("rr_c");
        advance();
        check("rr_d.grf_we", 32'(grf_we), 32'd0);

        // Starvation of S1 behind a continuous pipeline
        s_valid[1] = 1'b1; s_a3[1] = 5'd10; s_wd[1] = 32'hCAFE; s_pc[1] = 32'hA00;
        for (int k = 0; k < LIMIT; k++) begin
            p_valid = 1'b1; p_a3 = 5'd3; p_wd = 32'(k); p_pc = 32'h100 + 32'(k);
            settle("starve_wait");
            check("starve_wait.stall", 32'(stall), 32'd0);
            advance();
        end
        settle("starve_hit");
        check("starve_hit.stall",    32'(stall),    32'd1);
        check("starve_hit.s1_ready", 32'(s1_ready), 32'd1);
        advance();
        s_valid[1] = 1'b0;
        check("starve_wr.grf_a3", 32'(grf_a3), 32'd10);
        settle("starve_resume");
        advance();
        check("starve_p.grf_a3", 32'(grf_a3), 32'd3);
        idle();

        // $0 pipeline write alongside S0
        p_valid = 1'b1; p_a3 = 5'd0; p_wd = 32'hDEAD; p_pc = 32'h200;
        s_valid[0] = 1'b1; s_a3[0] = 5'd7; s_wd[0] = 32'h7777; s_pc[0] = 32'h700;
        settle("zero");
        check("zero.s0_ready", 32'(s0_ready), 32'd1);
        check("zero.pend7",    32'(pend_mask[7]), 32'd0);
        advance();
        idle();
        check("zero.grf_a3", 32'(grf_a3), 32'd7);
        settle("zero_n1");
        check("zero_n1.pend7", 32'(pend_mask[7]), 32'd1);
        advance();
        settle("zero_n2");
        check("zero_n2.pend7", 32'(pend_mask[7]), 32'd0);
        advance();

        // Same-register collision: P first, secondary last
        p_valid = 1'b1; p_a3 = 5'd12; p_wd = 32'hA; p_pc = 32'h300;
        s_valid[0] = 1'b1; s_a3[0] = 5'd12; s_wd[0] = 32'hB; s_pc[0] = 32'h310;
        settle("coll_a");
        check("coll_a.pend12", 32'(pend_mask[12]), 32'd1);
        advance();
        p_valid = 1'b0;
        check("coll_a.grf_wd", grf_wd, 32'hA);
        settle("coll_b");
        advance();
        idle();
        check("coll_b.grf_wd", grf_wd, 32'hB);
        settle("coll_c");
        advance();

        // Reset asserted while a write is on the port
        p_valid = 1'b1; p_a3 = 5'd6; p_wd = 32'h66; p_pc = 32'h600;
        settle("mid_pre");
        advance();
        p_valid = 1'b0;
        s_valid[0] = 1'b1; s_a3[0] = 5'd4; s_wd[0] = 32'h44; s_pc[0] = 32'h4400;
        check("mid.we_before", 32'(grf_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid.grf_we",   32'(grf_we),   32'd0);
        check("mid.grf_a3",   32'(grf_a3),   32'd0);
        check("mid.grf_wd",   grf_wd,        32'd0);
        check("mid.grf_pc",   grf_pc,        32'd0);
        check("mid.stall",    32'(stall),    32'd0);
        check("mid.s0_ready", 32'(s0_ready), 32'd0);
        reset = 1'b1;
        model_reset();
        settle("post_rst");
        check("post_rst.s0_ready", 32'(s0_ready), 32'd1);
        advance();
        idle();
        check("post_rst.grf_we", 32'(grf_we), 32'd1);
        check("post_rst.grf_a3", 32'(grf_a3), 32'd4);
        settle("post_rst_n1");
        advance();

        // Random traffic obeying the handshake rules
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                if (!(s_valid[i] && !m_ready[i])) begin
                    if ($urandom_range(0, 2) != 0) begin
                        s_valid[i] = 1'b1;
                        s_a3[i] = pick_reg();
                        s_wd[i] = $urandom;
                        s_pc[i] = $urandom;
                    end else begin
                        s_valid[i] = 1'b0;
                    end
                end
            end
            if (!(p_valid && m_stall)) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_a3 = pick_reg();
                p_wd = $urandom;
                p_pc = $urandom;
            end
            settle("rand");
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
